// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the multicycle RV64 ALU (alu_mc).
//   - func3 / func7 encodings of the RV integer register-register ops
//   - FSM state encoding for the iterative multiply sequencer
//   - flag bundle carried alongside every registered result
//   - f7_f3_legal(): which func7/func3 pairs the ALU executes
package alu_pkg;

  localparam logic [2:0] F3_ADD  = 3'b000;  // add / sub / mul
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;  // srl / sra
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    MUL_WB  = 2'd2
  } state_e;

  typedef struct packed {
    logic zero;
    logic cout;
    logic overflow;
    logic sign;
    logic err;
  } flags_t;

  // F7_ALT only modifies add (-> sub) and srl (-> sra); F7_MULDIV only
  // exists as mul. Everything else is reported as an illegal op.
  function automatic logic f7_f3_legal(input logic [6:0] f7, input logic [2:0] f3);
    logic ok;
    case (f7)
      F7_BASE:   ok = 1'b1;
      F7_ALT:    ok = (f3 == F3_ADD) || (f3 == F3_SRL);
      F7_MULDIV: ok = (f3 == F3_ADD);
      default:   ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier retiring MUL_BITS_PER_CYCLE multiplier
// bits per clock. Produces the low DATA_WIDTH bits of a*b.
//
// The first chunk is retired on the start edge itself (the accumulator is
// loaded with the first partial product instead of zero), so a run of N
// iterations occupies the start edge plus N-1 further edges.
//
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   i_start      load operands and retire the first chunk
//   i_a, i_b     multiplicand / multiplier (sampled on i_start)
//   i_iters      number of iterations for this run (sampled on i_start)
//   o_busy       iterations still pending after the current edge chain
//   o_done       the final iteration happens on the coming edge
//   o_product    accumulator (final once o_busy has dropped)
module alu_mul_iter #(
  parameter int DATA_WIDTH         = 64,
  parameter int MUL_BITS_PER_CYCLE = 1,
  parameter int CW                 = $clog2(DATA_WIDTH / MUL_BITS_PER_CYCLE + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [CW-1:0]         i_iters,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_product
);

  logic [DATA_WIDTH-1:0] r_a;
  logic [DATA_WIDTH-1:0] r_b;
  logic [DATA_WIDTH-1:0] r_acc;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_iters;
  logic                  r_busy;

  logic [DATA_WIDTH-1:0] w_src_a;
  logic [DATA_WIDTH-1:0] w_src_b;
  logic [DATA_WIDTH-1:0] w_base;
  logic [DATA_WIDTH-1:0] w_partial;
  logic [DATA_WIDTH-1:0] w_sum;

  always_comb begin
    w_src_a   = i_start ? i_a : r_a;
    w_src_b   = i_start ? i_b : r_b;
    w_base    = i_start ? '0  : r_acc;
    w_partial = '0;
    for (int j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
      if (w_src_b[j]) w_partial = w_partial + (w_src_a << j);
    end
    w_sum = w_base + w_partial;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_iters <= '0;
      r_busy  <= 1'b0;
    end else if (i_start) begin
      r_acc   <= w_sum;
      r_a     <= i_a << MUL_BITS_PER_CYCLE;
      r_b     <= i_b >> MUL_BITS_PER_CYCLE;
      r_cnt   <= CW'(1);
      r_iters <= i_iters;
      r_busy  <= (i_iters > CW'(1));
    end else if (r_busy) begin
      r_acc <= w_sum;
      r_a   <= r_a << MUL_BITS_PER_CYCLE;
      r_b   <= r_b >> MUL_BITS_PER_CYCLE;
      r_cnt <= r_cnt + CW'(1);
      if (r_cnt == r_iters - CW'(1)) r_busy <= 1'b0;
    end
  end

  assign o_busy    = r_busy;
  assign o_done    = r_busy && (r_cnt == r_iters - CW'(1));
  assign o_product = r_acc;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multicycle, valid/ready handshaked RV64 integer ALU.
//   Base ALU ops complete in one registered cycle; MUL (func7=0000001)
//   runs on the iterative alu_mul_iter and is written back afterwards.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its payload stable while valid && !ready;
// the output slot holds result and flags stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operation handshake (in_ready only in IDLE, slot free)
//   func3, func7        RV operation encoding
//   data_rs1, data_rs2  operands A and B
//   out_valid/out_ready result handshake
//   result              registered result
//   zero, cout, overflow, sign, err   registered flags
//   o_dbg_state         current sequencer state
//
// Optional build macro ALU_WORD_OPS_EN adds the op_word input (RV64 *W
// ops: 32-bit add/sub/sll/srl/sra/mul, sign-extended); needs DATA_WIDTH==64.
module alu_mc
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH         = 64,
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            func3,
  input  logic [6:0]            func7,
  input  logic [DATA_WIDTH-1:0] data_rs1,
  input  logic [DATA_WIDTH-1:0] data_rs2,
`ifdef ALU_WORD_OPS_EN
  input  logic                  op_word,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  zero,
  output logic                  cout,
  output logic                  overflow,
  output logic                  sign,
  output logic                  err,
  output state_e                o_dbg_state
);

  localparam int SHW   = $clog2(DATA_WIDTH);
  localparam int ITERS = DATA_WIDTH / MUL_BITS_PER_CYCLE;
  localparam int CW    = $clog2(ITERS + 1);
  localparam int MSB   = DATA_WIDTH - 1;

  if ((DATA_WIDTH < 8) || ((DATA_WIDTH & (DATA_WIDTH - 1)) != 0)) begin : g_bad_width
    $error("alu_mc: DATA_WIDTH must be a power of two >= 8");
  end
  if ((MUL_BITS_PER_CYCLE < 1) || ((DATA_WIDTH % MUL_BITS_PER_CYCLE) != 0)) begin : g_bad_mul
    $error("alu_mc: MUL_BITS_PER_CYCLE must divide DATA_WIDTH");
  end
`ifdef ALU_WORD_OPS_EN
  if (DATA_WIDTH != 64) begin : g_bad_word
    $error("alu_mc: ALU_WORD_OPS_EN requires DATA_WIDTH == 64");
  end
`endif

  state_e                r_state;
  state_e                w_state_next;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_result;
  flags_t                r_flags;

  logic                  w_slot_free;
  logic                  w_accept;
  logic                  w_legal;
  logic                  w_is_mul;
  logic                  w_mul_start;
  logic                  w_wb;
  logic                  w_mul_busy;
  logic                  w_mul_done;
  logic [DATA_WIDTH-1:0] w_mul_product;
  logic [DATA_WIDTH-1:0] w_mul_a;
  logic [DATA_WIDTH-1:0] w_mul_b;
  logic [CW-1:0]         w_mul_iters;
  logic [DATA_WIDTH-1:0] w_mul_res;

  logic [SHW-1:0]        w_shamt;
  logic [DATA_WIDTH:0]   w_add;
  logic [DATA_WIDTH:0]   w_sub;
  logic [DATA_WIDTH-1:0] w_res;
  logic                  w_cout;
  logic                  w_ovf;
  logic [DATA_WIDTH-1:0] w_exec_result;
  flags_t                w_exec_flags;

`ifdef ALU_WORD_OPS_EN
  logic        r_mul_word;
  logic [32:0] w_add32;
  logic [32:0] w_sub32;
  logic [31:0] w_r32;
  logic        w_c32;
  logic        w_o32;
`endif

  // ---------------------------------------------------------------- execute
  assign w_shamt = data_rs2[SHW-1:0];

  always_comb begin
    w_res  = '0;
    w_cout = 1'b0;
    w_ovf  = 1'b0;
    w_add  = {1'b0, data_rs1} + {1'b0, data_rs2};
    // a + ~b + 1: the carry out is the RV "no borrow" indication.
    w_sub  = {1'b0, data_rs1} + {1'b0, ~data_rs2} + {{DATA_WIDTH{1'b0}}, 1'b1};
    case (func3)
      F3_ADD: begin
        if (func7 == F7_ALT) begin
          w_res  = w_sub[MSB:0];
          w_cout = w_sub[DATA_WIDTH];
          w_ovf  = (data_rs1[MSB] != data_rs2[MSB]) && (w_sub[MSB] != data_rs1[MSB]);
        end else begin
          w_res  = w_add[MSB:0];
          w_cout = w_add[DATA_WIDTH];
          w_ovf  = (data_rs1[MSB] == data_rs2[MSB]) && (w_add[MSB] != data_rs1[MSB]);
        end
      end
      F3_SLL:  w_res = data_rs1 << w_shamt;
      F3_SLT:  w_res[0] = $signed(data_rs1) < $signed(data_rs2);
      F3_SLTU: w_res[0] = data_rs1 < data_rs2;
      F3_XOR:  w_res = data_rs1 ^ data_rs2;
      F3_SRL:  w_res = (func7 == F7_ALT) ? DATA_WIDTH'($signed(data_rs1) >>> w_shamt)
                                         : (data_rs1 >> w_shamt);
      F3_OR:   w_res = data_rs1 | data_rs2;
      F3_AND:  w_res = data_rs1 & data_rs2;
      default: w_res = '0;
    endcase
`ifdef ALU_WORD_OPS_EN
    w_add32 = {1'b0, data_rs1[31:0]} + {1'b0, data_rs2[31:0]};
    w_sub32 = {1'b0, data_rs1[31:0]} + {1'b0, ~data_rs2[31:0]} + 33'd1;
    w_r32   = '0;
    w_c32   = 1'b0;
    w_o32   = 1'b0;
    if (op_word) begin
      case (func3)
        F3_ADD: begin
          if (func7 == F7_ALT) begin
            w_r32 = w_sub32[31:0];
            w_c32 = w_sub32[32];
            w_o32 = (data_rs1[31] != data_rs2[31]) && (w_sub32[31] != data_rs1[31]);
          end else begin
            w_r32 = w_add32[31:0];
            w_c32 = w_add32[32];
            w_o32 = (data_rs1[31] == data_rs2[31]) && (w_add32[31] != data_rs1[31]);
          end
        end
        F3_SLL:  w_r32 = data_rs1[31:0] << data_rs2[4:0];
        F3_SRL:  w_r32 = (func7 == F7_ALT) ? 32'($signed(data_rs1[31:0]) >>> data_rs2[4:0])
                                           : (data_rs1[31:0] >> data_rs2[4:0]);
        default: w_r32 = '0;
      endcase
      w_res  = {{(DATA_WIDTH-32){w_r32[31]}}, w_r32};
      w_cout = w_c32;
      w_ovf  = w_o32;
    end
`endif
  end

`ifdef ALU_WORD_OPS_EN
  assign w_legal = f7_f3_legal(func7, func3) &&
                   (!op_word || (func3 == F3_ADD) || (func3 == F3_SLL) || (func3 == F3_SRL));
`else
  assign w_legal = f7_f3_legal(func7, func3);
`endif
  assign w_is_mul = w_legal && (func7 == F7_MULDIV);

  // Illegal ops still occupy one slot cycle so the consumer sees err=1.
  always_comb begin
    w_exec_result = '0;
    w_exec_flags  = '0;
    if (!w_legal) begin
      w_exec_flags.zero = 1'b1;
      w_exec_flags.err  = 1'b1;
    end else begin
      w_exec_result          = w_res;
      w_exec_flags.zero      = (w_res == '0);
      w_exec_flags.cout      = w_cout;
      w_exec_flags.overflow  = w_ovf;
      w_exec_flags.sign      = w_res[MSB];
    end
  end

  // ---------------------------------------------------------------- multiply
`ifdef ALU_WORD_OPS_EN
  assign w_mul_a     = op_word ? {32'b0, data_rs1[31:0]} : data_rs1;
  assign w_mul_b     = op_word ? {32'b0, data_rs2[31:0]} : data_rs2;
  assign w_mul_iters = op_word ? CW'(32 / MUL_BITS_PER_CYCLE) : CW'(ITERS);
  assign w_mul_res   = r_mul_word ? {{(DATA_WIDTH-32){w_mul_product[31]}}, w_mul_product[31:0]}
                                  : w_mul_product;

  always_ff @(posedge clk) begin
    if (rst)              r_mul_word <= 1'b0;
    else if (w_mul_start) r_mul_word <= op_word;
  end
`else
  assign w_mul_a     = data_rs1;
  assign w_mul_b     = data_rs2;
  assign w_mul_iters = CW'(ITERS);
  assign w_mul_res   = w_mul_product;
`endif

  alu_mul_iter #(
    .DATA_WIDTH        (DATA_WIDTH),
    .MUL_BITS_PER_CYCLE(MUL_BITS_PER_CYCLE),
    .CW                (CW)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_mul_start),
    .i_a      (w_mul_a),
    .i_b      (w_mul_b),
    .i_iters  (w_mul_iters),
    .o_busy   (w_mul_busy),
    .o_done   (w_mul_done),
    .o_product(w_mul_product)
  );

  // ---------------------------------------------------------------- control
  assign w_slot_free = !r_out_valid || out_ready;
  assign in_ready    = (r_state == IDLE) && w_slot_free;
  assign w_accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_mul_start  = 1'b0;
    w_wb         = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && w_is_mul) begin
          w_mul_start  = 1'b1;
          w_state_next = MUL_RUN;
        end
      end
      // !busy covers single-iteration runs that finish on the start edge.
      MUL_RUN: if (w_mul_done || !w_mul_busy) w_state_next = MUL_WB;
      MUL_WB: begin
        if (w_slot_free) begin
          w_wb         = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- output slot
  // A new write wins over a same-cycle drain, so out_valid stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid <= 1'b1;
      r_result    <= w_exec_result;
      r_flags     <= w_exec_flags;
    end else if (w_wb) begin
      r_out_valid      <= 1'b1;
      r_result         <= w_mul_res;
      r_flags          <= '0;
      r_flags.zero     <= (w_mul_res == '0);
      r_flags.sign     <= w_mul_res[MSB];
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign result      = r_result;
  assign zero        = r_flags.zero;
  assign cout        = r_flags.cout;
  assign overflow    = r_flags.overflow;
  assign sign        = r_flags.sign;
  assign err         = r_flags.err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;
  import alu_pkg::*;

  localparam int W = 64;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         in_valid;
  logic         in_ready;
  logic [2:0]   func3;
  logic [6:0]   func7;
  logic [W-1:0] data_rs1;
  logic [W-1:0] data_rs2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero, cout, overflow, sign, err;
  state_e       dbg_state;
`ifdef ALU_WORD_OPS_EN
  logic         op_word = 1'b0;
`endif

  alu_mc #(.DATA_WIDTH(W), .MUL_BITS_PER_CYCLE(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .func3      (func3),
    .func7      (func7),
    .data_rs1   (data_rs1),
    .data_rs2   (data_rs2),
`ifdef ALU_WORD_OPS_EN
    .op_word    (op_word),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .zero       (zero),
    .cout       (cout),
    .overflow   (overflow),
    .sign       (sign),
    .err        (err),
    .o_dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------- scoreboard
  int           total = 0;
  int           bad   = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] flags_now();
    return {zero, cout, overflow, sign, err};
  endfunction

  // ---------------------------------------------------------------- vectors
  typedef struct packed {
    logic [2:0]   f3;
    logic [6:0]   f7;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [4:0]   flg;  // {zero, cout, overflow, sign, err}
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  // ---------------------------------------------------------------- driver tasks
  task automatic drive(input logic [2:0] f3, input logic [6:0] f7,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    func3    = f3;
    func7    = f7;
    data_rs1 = a;
    data_rs2 = b;
    in_valid = 1'b1;
  endtask

  task automatic apply_vec(input vec_t v, input int idx);
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    drive(v.f3, v.f7, v.a, v.b);
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk($sformatf("v%0d_ready", idx), W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk($sformatf("v%0d_valid", idx), W'(out_valid), W'(1));
    chk($sformatf("v%0d_result", idx), result, v.res);
    chk($sformatf("v%0d_flags", idx), W'(flags_now()), W'(v.flg));
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    int           lat;
    int           sent, got, cyc;
    logic         stable, seen, out_fire, in_fire;
    logic [W-1:0] sa, sb;

    vecs[0]  = '{F3_ADD,  F7_BASE,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,                    5'b11000};
    vecs[1]  = '{F3_ADD,  F7_ALT,    64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,  5'b01100};
    vecs[2]  = '{F3_SLT,  F7_BASE,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd1,                    5'b00000};
    vecs[3]  = '{F3_SLTU, F7_BASE,   64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0,                    5'b10000};
    vecs[4]  = '{F3_SRL,  F7_ALT,    64'h8000_0000_0000_0000, 64'h43, 64'hF000_0000_0000_0000, 5'b00010};
    vecs[5]  = '{F3_SRL,  F7_BASE,   64'h8000_0000_0000_0000, 64'h43, 64'h1000_0000_0000_0000, 5'b00000};
    vecs[6]  = '{F3_SLL,  F7_BASE,   64'd1, 64'h3F, 64'h8000_0000_0000_0000,                  5'b00010};
    vecs[7]  = '{F3_XOR,  F7_BASE,   64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00,
                 64'h0FF0_0FF0_0FF0_0FF0, 5'b00000};
    vecs[8]  = '{F3_OR,   F7_BASE,   64'h00FF, 64'hFF00, 64'hFFFF,                            5'b00000};
    vecs[9]  = '{F3_AND,  F7_BASE,   64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F,
                 64'h0F0F_0000_0F0F_0000, 5'b00000};
    vecs[10] = '{F3_ADD,  F7_BASE,   64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,  5'b00110};
    vecs[11] = '{F3_ADD,  F7_ALT,    64'd5, 64'd5, 64'd0,                                     5'b11000};
    vecs[12] = '{F3_ADD,  F7_ALT,    64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF,                   5'b00010};
    vecs[13] = '{F3_AND,  F7_ALT,    64'd7, 64'd3, 64'd0,                                     5'b10001};
    vecs[14] = '{F3_SLL,  F7_MULDIV, 64'd7, 64'd3, 64'd0,                                     5'b10001};
    vecs[15] = '{F3_ADD,  7'b0000010, 64'd7, 64'd3, 64'd0,                                    5'b10001};
    vecs[16] = '{F3_SRL,  F7_ALT,    64'h7000_0000_0000_0000, 64'd4, 64'h0700_0000_0000_0000,  5'b00000};
    vecs[17] = '{F3_ADD,  F7_BASE,   64'd3, 64'd4, 64'd7,                                     5'b00000};

    // reset
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    func3 = '0;
    func7 = '0;
    data_rs1 = '0;
    data_rs2 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_out_valid", W'(out_valid), W'(0));
    chk("reset_result", result, '0);
    chk("reset_flags", W'(flags_now()), W'(0));
    chk("reset_state", W'(dbg_state), W'(IDLE));
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", W'(in_ready), W'(1));

    // single-cycle ops
    for (int i = 0; i < NV; i++) apply_vec(vecs[i], i);

    // add in flight, then mul presented while the add result drains
    @(negedge clk);
    out_ready = 1'b1;
    drive(F3_ADD, F7_BASE, 64'd2, 64'd3);
    @(posedge clk);
    @(negedge clk);
    drive(F3_ADD, F7_MULDIV, 64'h1_0000_0003, 64'd5);
    #1;
    chk("pre_add_result", result, 64'd5);
    chk("mul_accept_ready", W'(in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid  = 1'b0;
    data_rs1  = 64'hDEAD_BEEF_0000_0001;  // must not disturb the running mul
    data_rs2  = 64'h1234;
    out_ready = 1'b0;
    chk("pre_add_drained", W'(out_valid), W'(0));
    chk("mul_state_run", W'(dbg_state), W'(MUL_RUN));
    chk("mul_busy_not_ready", W'(in_ready), W'(0));
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("mul_latency", W'(lat), W'(65));
    chk("mul_result", result, 64'h5_0000_000F);
    chk("mul_flags", W'(flags_now()), W'(0));
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (!out_valid || result !== 64'h5_0000_000F || in_ready) stable = 1'b0;
    end
    chk("mul_hold_stable", W'(stable), W'(1));
    out_ready = 1'b1;
    @(negedge clk);
    chk("mul_drained", W'(out_valid), W'(0));
    chk("mul_drained_ready", W'(in_ready), W'(1));

    // reset in the middle of a multiply
    drive(F3_ADD, F7_MULDIV, 64'h1_0000_0003, 64'd5);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mul_state", W'(dbg_state), W'(IDLE));
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("rst_mul_no_result", W'(seen), W'(0));
    chk("rst_mul_result_zero", result, '0);
    chk("rst_mul_in_ready", W'(in_ready), W'(1));

    // back-to-back xor stream under toggling backpressure
    sent = 0;
    got  = 0;
    cyc  = 0;
    while ((sent < 8 || got < 8) && cyc < 200) begin
      @(negedge clk);
      cyc++;
      out_ready = (cyc % 2) == 1;
      if (sent < 8) begin
        sa = 64'h0123_4567_89AB_CDEF + W'(sent * 64'h1111);
        sb = 64'hFFFF_0000_FFFF_0000 >> sent;
        drive(F3_XOR, F7_BASE, sa, sb);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      out_fire = out_valid && out_ready;
      in_fire  = in_valid && in_ready;
      if (out_fire) begin
        if (exp_q.size() == 0) chk("stream_spurious", W'(1), W'(0));
        else chk($sformatf("stream_res%0d", got), result, exp_q.pop_front());
        got++;
      end
      if (in_fire) begin
        exp_q.push_back(sa ^ sb);
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("stream_sent", W'(sent), W'(8));
    chk("stream_got", W'(got), W'(8));
    chk("stream_queue_empty", W'(exp_q.size()), W'(0));
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk("stream_no_extra", W'(seen), W'(0));

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multicycle, handshaked successor to the single-cycle combinational ALU for the RV64 integer datapath.
- Executes the RV base ALU operations (add, sub, sll, slt, sltu, xor, srl, sra, or, and) with one registered cycle of latency.
- Adds an iterative MUL selected by func7=0000001.
- Sits between the decode/operand-read stage and writeback; valid/ready on both sides lets writeback stall it.

Parameters:
- DATA_WIDTH, 64, operand/result width; power of two, >= 8.
- MUL_BITS_PER_CYCLE, 1, multiplier bits retired per iteration; must divide DATA_WIDTH.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation presented
- in_ready  out  1  operation accepted when in_valid && in_ready
- func3  in  3  RV func3
- func7  in  7  RV func7 (0000000 normal, 0100000 sub/sra, 0000001 mul)
- data_rs1  in  DATA_WIDTH  operand A
- data_rs2  in  DATA_WIDTH  operand B
- out_valid  out  1  result held stable until out_ready
- out_ready  in  1  consumer accepts
- result  out  DATA_WIDTH  result
- zero  out  1  result == 0
- cout  out  1  add: carry out; sub: NOT borrow; otherwise 0
- overflow  out  1  signed overflow for add/sub only, otherwise 0
- sign  out  1  result[DATA_WIDTH-1]
- err  out  1  illegal func3/func7 combination; result 0

Behaviour:
- Reset: state IDLE; out_valid=0, result=0, zero=0, cout=0, overflow=0, sign=0, err=0, iteration counter 0.
- Output slot: a one-entry register. It is free when !out_valid || out_ready.
- in_ready = (state==IDLE) && slot free. Non-MUL ops therefore sustain 1 op/cycle with zero bubbles under continuous out_ready.
- Non-MUL op accepted at cycle N: result and flags registered; out_valid=1 at N+1.
- If out_valid && !out_ready: result and flags hold; in_ready=0.
- Shift amount = data_rs2[$clog2(DATA_WIDTH)-1:0].
  - sra is arithmetic: sign-filled from data_rs1 MSB.
  - srl is zero-filled.
- slt compares both operands signed; sltu compares both unsigned. Result is 0 or 1.
- Legal func7 values:
  - 0100000: legal only with func3 000 (sub) or 101 (sra).
  - 0000001: legal only with func3 000 (mul).
  - Any other func7/func3 combination: one-cycle response with err=1, result=0, zero=1.
- zero is computed from the final result. cout and overflow are 0 for all non-add/sub ops.
- MUL FSM states: IDLE -> MUL_RUN -> MUL_WB -> IDLE.
  - Accept in IDLE: latch operands, clear accumulator, enter MUL_RUN.
  - MUL_RUN: shift-add MUL_BITS_PER_CYCLE bits per cycle for DATA_WIDTH/MUL_BITS_PER_CYCLE cycles, then go to MUL_WB.
  - MUL_WB: write the low DATA_WIDTH bits of the product to the output slot when it is free, then go to IDLE. Otherwise stay in MUL_WB.
  - Minimum latency from accept to out_valid = DATA_WIDTH/MUL_BITS_PER_CYCLE + 1 cycles (65 at defaults).
  - For MUL: cout=0, overflow=0.
- in_ready=0 throughout MUL_RUN and MUL_WB. A result from an op issued before the MUL may still drain during MUL_RUN.
- Simultaneous slot drain and new accept in the same cycle: the new result overwrites the slot and out_valid stays 1.
- rst mid-MUL: abort immediately, return to reset values, no result produced.
- Inputs are sampled only on accept. Changing operands while in_ready=0 has no effect.

Optional Feature:
- Macro: ALU_WORD_OPS_EN.
- Defined:
  - Adds input port op_word (1 bit).
  - op_word=1 with add/sub/sll/srl/sra/mul operates on the low 32 bits, using a 5-bit shift amount, and sign-extends bit 31 to DATA_WIDTH (RV64 *W semantics).
  - op_word=1 with any other func3 gives err=1.
  - MUL with op_word runs 32/MUL_BITS_PER_CYCLE iterations.
  - Requires DATA_WIDTH==64; elaboration error otherwise.
- Undefined: no op_word port; all ops are full-width.

Decomposition:
- Package alu_pkg:
  - func3 constants: ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
  - func7 constants: F7_BASE, F7_ALT, F7_MULDIV.
  - FSM state enum: IDLE, MUL_RUN, MUL_WB.
  - Flag bundle struct: zero, cout, overflow, sign, err.
- Sub-module alu_mul_iter: start/busy/done interface, parameterised by DATA_WIDTH and MUL_BITS_PER_CYCLE, holding the operand shift registers and the iteration counter.

Test Plan:
- add: rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 -> result=0, zero=1, cout=1, overflow=0, out_valid exactly 1 cycle after accept.
- sub: rs1=0x8000_0000_0000_0000, rs2=1 -> result=0x7FFF_FFFF_FFFF_FFFF, overflow=1, cout=1, sign=0.
- slt rs1=-1, rs2=1 -> result=1. sltu with the same operands -> result=0.
- sra: rs1=0x8000_0000_0000_0000, rs2=0x43 -> result=0xF000_0000_0000_0000 (shift amount 3). srl with the same operands -> 0x1000_0000_0000_0000.
- mul: rs1=0x1_0000_0003, rs2=5 -> result=0x5_0000_000F after 65 cycles. Hold out_ready=0 for 10 cycles: result stable and in_ready=0. rst at iteration 20 -> out_valid never rises.
- Backpressure stream: 8 back-to-back xor ops with out_ready toggling 1,0,1,0... -> results in issue order, none lost or duplicated. func7=0100000 with func3=111 -> err=1, result=0.
